// File: rtl/sevenseg_output_stage.sv
// Seven-segment output stage: brightness PWM passthrough with a spin-then-glyph splash on game switch.
// All outputs registered, one clk after inputs; no backpressure (free-running display path).
module sevenseg_output_stage #(
  parameter int TICK_DIV   = 250000,
  parameter int ANIM_STEPS = 6,
  parameter int HOLD_TICKS = 40,
  parameter int PWM_BITS   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          seg_in,
  input  logic                splash_start,
  input  logic [1:0]          splash_id,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [6:0]          seg_out,
  output logic                dp_out,
  output logic                busy
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int STEP_W = $clog2(ANIM_STEPS + 1);
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  typedef enum logic [1:0] {PASS, SPIN, HOLD} state_t;

  state_t              state, state_n;
  logic [TICK_W-1:0]   tick_cnt, tick_cnt_n;
  logic [STEP_W-1:0]   step, step_n;
  logic [2:0]          pos, pos_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
  logic [1:0]          id, id_n;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;
  logic                en;
  logic [6:0]          raw;

  function automatic logic [6:0] glyph(input logic [1:0] gid);
    case (gid)
      2'd0:    glyph = 7'b0111001;
      2'd1:    glyph = 7'b1011110;
      2'd2:    glyph = 7'b1110110;
      default: glyph = 7'b1010000;
    endcase
  endfunction

  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign en   = (&brightness) | ((brightness != '0) && (pwm_cnt < brightness));

  // pos tracks step mod 6 so the spin wraps cleanly when ANIM_STEPS exceeds six
  always_comb begin
    state_n    = state;
    step_n     = step;
    pos_n      = pos;
    hold_cnt_n = hold_cnt;
    id_n       = id;
    tick_cnt_n = (splash_start || tick) ? '0 : tick_cnt + 1'b1;
    if (splash_start) begin
      state_n = SPIN;
      step_n  = '0;
      pos_n   = '0;
      id_n    = splash_id;
    end else if (tick) begin
      case (state)
        SPIN: begin
          if (step == STEP_W'(ANIM_STEPS - 1)) begin
            state_n    = HOLD;
            hold_cnt_n = '0;
          end else begin
            step_n = step + 1'b1;
            pos_n  = (pos == 3'd5) ? 3'd0 : pos + 3'd1;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_W'(HOLD_TICKS - 1)) state_n = PASS;
          else hold_cnt_n = hold_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    raw = seg_in;
    case (state_n)
      SPIN:    raw = 7'b0000001 << pos_n;
      HOLD:    raw = glyph(id_n);
      default: raw = seg_in;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= PASS;
      tick_cnt <= '0;
      step     <= '0;
      pos      <= '0;
      hold_cnt <= '0;
      id       <= '0;
      pwm_cnt  <= '0;
      seg_out  <= '0;
      dp_out   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      step     <= step_n;
      pos      <= pos_n;
      hold_cnt <= hold_cnt_n;
      id       <= id_n;
      pwm_cnt  <= pwm_cnt + 1'b1;
      seg_out  <= en ? raw : 7'b0;
      dp_out   <= en & (state_n != PASS);
      busy     <= (state_n != PASS);
    end
  end

endmodule

// File: tb/tb_sevenseg_output_stage.sv
// Directed bench for sevenseg_output_stage with a short tick period (TICK_DIV=4, HOLD_TICKS=3).
module tb_sevenseg_output_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg_in;
  logic       splash_start;
  logic [1:0] splash_id;
  logic [3:0] brightness;
  logic [6:0] seg_out;
  logic       dp_out;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  sevenseg_output_stage #(
    .TICK_DIV(4), .ANIM_STEPS(6), .HOLD_TICKS(3), .PWM_BITS(4)
  ) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .splash_start(splash_start),
    .splash_id(splash_id), .brightness(brightness),
    .seg_out(seg_out), .dp_out(dp_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // advance one clk; outputs are then sampled 1 time unit after the edge
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] gid);
    splash_start = 1'b1;
    splash_id    = gid;
    step_clk();
    splash_start = 1'b0;
    splash_id    = 2'd0;
  endtask

  // called just after the start edge; checks 24 spin + 12 hold clks, then passthrough
  task automatic run_splash(input logic [6:0] exp_glyph, input logic [6:0] pass_seg);
    logic [6:0] exp_seg;
    int         bad_seg = 0, bad_busy = 0, busy_cnt = 0;
    for (int i = 0; i < 36; i++) begin
      exp_seg = (i < 24) ? (7'b0000001 << (i / 4)) : exp_glyph;
      if (seg_out !== exp_seg) bad_seg++;
      if (busy !== 1'b1 || dp_out !== 1'b1) bad_busy++;
      if (busy === 1'b1) busy_cnt++;
      if (i == 0)  chk("splash_first_a", {1'b0, seg_out}, 8'h01);
      if (i == 24) chk("splash_glyph", {1'b0, seg_out}, {1'b0, exp_glyph});
      step_clk();
    end
    chk("splash_seg_seq_errs", 8'(bad_seg), 8'd0);
    chk("splash_busy_dp_errs", 8'(bad_busy), 8'd0);
    chk("splash_busy_len", 8'(busy_cnt), 8'd36);
    chk("splash_end_busy", {7'b0, busy}, 8'd0);
    chk("splash_end_dp", {7'b0, dp_out}, 8'd0);
    chk("splash_end_seg", {1'b0, seg_out}, {1'b0, pass_seg});
  endtask

  initial begin
    int on_cnt, dp_cnt, busy_cnt, bad;
    reset        = 1'b1;
    seg_in       = 7'h00;
    splash_start = 1'b0;
    splash_id    = 2'd0;
    brightness   = 4'hF;
    #1;
    chk("rst_seg", {1'b0, seg_out}, 8'h00);
    chk("rst_dp", {7'b0, dp_out}, 8'd0);
    chk("rst_busy", {7'b0, busy}, 8'd0);
    step_clk();
    step_clk();
    reset = 1'b0;
    seg_in = 7'h5B;
    step_clk();
    chk("pass_seg", {1'b0, seg_out}, 8'h5B);

    // full splash with id 2 -> 'H'
    pulse_start(2'd2);
    run_splash(7'b1110110, 7'h5B);

    // reset asserted while the glyph is shown
    pulse_start(2'd1);
    for (int i = 0; i < 28; i++) step_clk();
    chk("midhold_busy", {7'b0, busy}, 8'd1);
    chk("midhold_seg", {1'b0, seg_out}, 8'h5E);
    #3 reset = 1'b1;
    #1;
    chk("rst_async_seg", {1'b0, seg_out}, 8'h00);
    chk("rst_async_dp", {7'b0, dp_out}, 8'd0);
    chk("rst_async_busy", {7'b0, busy}, 8'd0);
    step_clk();
    reset  = 1'b0;
    seg_in = 7'h3F;
    step_clk();
    chk("post_rst_seg", {1'b0, seg_out}, 8'h3F);
    chk("post_rst_busy", {7'b0, busy}, 8'd0);

    // restart in spin step 3 with a new id
    pulse_start(2'd1);
    for (int i = 0; i < 12; i++) step_clk();
    chk("restart_pre_step3", {1'b0, seg_out}, 8'h08);
    pulse_start(2'd3);
    run_splash(7'b1010000, 7'h3F);

    // start coincides with the final hold tick
    pulse_start(2'd0);
    bad = 0;
    for (int i = 0; i < 35; i++) begin
      if (busy !== 1'b1) bad++;
      step_clk();
    end
    chk("simul_busy_gaps", 8'(bad), 8'd0);
    chk("simul_last_glyph", {1'b0, seg_out}, 8'h39);
    pulse_start(2'd3);
    run_splash(7'b1010000, 7'h3F);

    // PWM duty in passthrough
    seg_in = 7'h7F;
    for (int b = 0; b < 3; b++) begin
      brightness = (b == 0) ? 4'd4 : (b == 1) ? 4'd0 : 4'hF;
      step_clk();
      on_cnt = 0;
      bad    = 0;
      for (int i = 0; i < 16; i++) begin
        if (seg_out === 7'h7F) on_cnt++;
        else if (seg_out !== 7'h00) bad++;
        if (dp_out !== 1'b0 || busy !== 1'b0) bad++;
        step_clk();
      end
      chk("pwm_on_count", 8'(on_cnt), (b == 0) ? 8'd4 : (b == 1) ? 8'd0 : 8'd16);
      chk("pwm_bad_values", 8'(bad), 8'd0);
    end

    // PWM gating during the spin
    brightness = 4'd8;
    pulse_start(2'd0);
    on_cnt = 0; dp_cnt = 0; busy_cnt = 0; bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (seg_out !== 7'h00) begin
        on_cnt++;
        if (seg_out !== (7'b0000001 << (i / 4))) bad++;
      end
      if (dp_out === 1'b1) dp_cnt++;
      if (busy === 1'b1) busy_cnt++;
      step_clk();
    end
    chk("pwm_spin_seg_on", 8'(on_cnt), 8'd8);
    chk("pwm_spin_dp_on", 8'(dp_cnt), 8'd8);
    chk("pwm_spin_busy", 8'(busy_cnt), 8'd16);
    chk("pwm_spin_wrong_seg", 8'(bad), 8'd0);
    for (int i = 0; i < 24; i++) step_clk();
    chk("pwm_splash_done", {7'b0, busy}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
